bus_arbiter: RTL and testbench

//  Two-master, one-slave arbiter for the cpu's stb/ack/we/sel bus.

---
 rtl/bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_bus_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the stb/ack/we/sel memory bus, with a
// watchdog that completes hung transactions back to the requesting master.
module bus_arbiter #(
    parameter int unsigned TIMEOUT      = 255,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  gnt_o,
    output logic        timeout_o
);
    localparam int NUM_M = 2;
    localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } req_t;

    typedef enum logic [1:0] {IDLE, BUSY, TOUT} state_t;

    req_t [NUM_M-1:0]        req;
    logic [NUM_M-1:0]        stb;
    logic [NUM_M-1:0]        m_ack;
    logic [NUM_M-1:0][31:0]  m_dat;

    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tout_q, tout_d;
    logic          g_idx, g_stb, win1;

    assign stb    = {m1_stb_i, m0_stb_i};
    assign req[0] = {m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i};
    assign req[1] = {m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i};

    assign g_idx = gnt_q[1];
    assign g_stb = |(gnt_q & stb);
    // last holds the index of the previous winner; on a tie the other master wins
    assign win1  = stb[1] && (!stb[0] || !last_q);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        tout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|stb) begin
                    gnt_d   = win1 ? 2'b10 : 2'b01;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!g_stb && !s_ack_i) begin
                    gnt_d   = 2'b00;
                    last_d  = g_idx;
                    state_d = IDLE;
                end else if (s_ack_i) begin
                    // an ack on the limit cycle still wins over the watchdog
                    cnt_d = '0;
                end else if (TIMEOUT > 0 && g_stb) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = TOUT;
                        tout_d  = 1'b1;
                    end
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
                end
            end
            TOUT: begin
                if (!g_stb) begin
                    gnt_d   = 2'b00;
                    last_d  = g_idx;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // gating by the registered grant keeps every output at 0 during reset
    always_comb begin
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        m_ack   = '0;
        m_dat   = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (gnt_q[i]) begin
                s_stb_o  = stb[i] && (state_q == BUSY);
                s_we_o   = req[i].we;
                s_adr_o  = req[i].adr;
                s_dat_o  = req[i].dat;
                s_sel_o  = req[i].sel;
                m_ack[i] = (state_q == TOUT) || s_ack_i;
                m_dat[i] = (state_q == TOUT) ? TIMEOUT_DATA : s_dat_i;
            end
        end
    end

    assign m0_ack_o  = m_ack[0];
    assign m0_dat_o  = m_dat[0];
    assign m1_ack_o  = m_ack[1];
    assign m1_dat_o  = m_dat[1];
    assign gnt_o     = gnt_q;
    assign timeout_o = tout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios on a TIMEOUT=8 and a TIMEOUT=0
// instance sharing stimulus, plus a random run against a grant/datapath model.
module tb_bus_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        m0_stb, m0_we, m1_stb, m1_we;
    logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] s_rdat_in;
    logic        s_ack_in;
    logic        use_b;

    logic [31:0] a_m0_dat, a_m1_dat, a_s_adr, a_s_dat, b_m0_dat, b_m1_dat, b_s_adr, b_s_dat;
    logic        a_m0_ack, a_m1_ack, a_s_stb, a_s_we, a_to, b_m0_ack, b_m1_ack, b_s_stb, b_s_we, b_to;
    logic [3:0]  a_s_sel, b_s_sel;
    logic [1:0]  a_gnt, b_gnt;

    logic [31:0] m0_rdat, m1_rdat, s_adr, s_wdat;
    logic        m0_ack, m1_ack, s_stb, s_we, tmo;
    logic [3:0]  s_sel;
    logic [1:0]  gnt;

    assign m0_rdat = use_b ? b_m0_dat : a_m0_dat;
    assign m1_rdat = use_b ? b_m1_dat : a_m1_dat;
    assign m0_ack  = use_b ? b_m0_ack : a_m0_ack;
    assign m1_ack  = use_b ? b_m1_ack : a_m1_ack;
    assign s_stb   = use_b ? b_s_stb  : a_s_stb;
    assign s_we    = use_b ? b_s_we   : a_s_we;
    assign s_adr   = use_b ? b_s_adr  : a_s_adr;
    assign s_wdat  = use_b ? b_s_dat  : a_s_dat;
    assign s_sel   = use_b ? b_s_sel  : a_s_sel;
    assign gnt     = use_b ? b_gnt    : a_gnt;
    assign tmo     = use_b ? b_to     : a_to;

    bus_arbiter #(.TIMEOUT(8)) dut_a (
        .clk(clk), .rst_ni(rst_n),
        .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel),
        .m0_dat_o(a_m0_dat), .m0_ack_o(a_m0_ack),
        .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel),
        .m1_dat_o(a_m1_dat), .m1_ack_o(a_m1_ack),
        .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_adr_o(a_s_adr), .s_dat_o(a_s_dat), .s_sel_o(a_s_sel),
        .s_dat_i(s_rdat_in), .s_ack_i(s_ack_in), .gnt_o(a_gnt), .timeout_o(a_to)
    );

    bus_arbiter #(.TIMEOUT(0)) dut_b (
        .clk(clk), .rst_ni(rst_n),
        .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel),
        .m0_dat_o(b_m0_dat), .m0_ack_o(b_m0_ack),
        .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel),
        .m1_dat_o(b_m1_dat), .m1_ack_o(b_m1_ack),
        .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_adr_o(b_s_adr), .s_dat_o(b_s_dat), .s_sel_o(b_s_sel),
        .s_dat_i(s_rdat_in), .s_ack_i(s_ack_in), .gnt_o(b_gnt), .timeout_o(b_to)
    );

    int n_cmp, n_bad;

    function automatic logic [138:0] all_out();
        return {s_stb, s_we, s_adr, s_wdat, s_sel, gnt, m0_ack, m1_ack, m0_rdat, m1_rdat, tmo};
    endfunction

    task automatic clear_inputs();
        m0_stb = 0; m0_we = 0; m0_adr = 0; m0_wdat = 0; m0_sel = 0;
        m1_stb = 0; m1_we = 0; m1_adr = 0; m1_wdat = 0; m1_sel = 0;
        s_ack_in = 0; s_rdat_in = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m0_stb = 1; m1_stb = 1; m0_we = 1; m1_we = 1;
        m0_adr = 32'h1234; m1_adr = 32'h5678; m0_wdat = 32'h1; m1_wdat = 32'h2;
        m0_sel = 4'hF; m1_sel = 4'hF; s_ack_in = 1; s_rdat_in = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            use_b = d[0]; #1;
            n_cmp++;
            if (all_out() !== '0) begin
                n_bad++; $display("FAIL reset_outputs dut%0d: got %h want 0", d, all_out());
            end
        end
        use_b = 0;
    endtask

    task automatic test_single_read();
        use_b = 0; do_reset();
        m0_adr = 32'h100; m0_we = 0; m0_sel = 4'hF; m0_stb = 1; #1;
        n_cmp++; if ({gnt, s_stb} !== 3'b000) begin n_bad++; $display("FAIL t1_latency: got %b want 000", {gnt, s_stb}); end
        @(negedge clk);
        n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL t1_grant: got %b want 01", gnt); end
        n_cmp++; if ({s_stb, s_adr} !== {1'b1, 32'h100}) begin n_bad++; $display("FAIL t1_slave: got %h want 100000100", {s_stb, s_adr}); end
        @(negedge clk);
        n_cmp++; if (m0_ack !== 1'b0) begin n_bad++; $display("FAIL t1_noack: got %b want 0", m0_ack); end
        s_ack_in = 1; s_rdat_in = 32'h12345678; #1;
        n_cmp++;
        if ({m0_ack, m0_rdat, m1_ack, m1_rdat} !== {1'b1, 32'h12345678, 1'b0, 32'h0}) begin
            n_bad++; $display("FAIL t1_readdata: got %h want %h", {m0_ack, m0_rdat, m1_ack, m1_rdat}, {1'b1, 32'h12345678, 1'b0, 32'h0});
        end
        @(negedge clk); m0_stb = 0; #1;
        n_cmp++; if ({s_stb, m0_ack} !== 2'b01) begin n_bad++; $display("FAIL t1_stb_drop: got %b want 01", {s_stb, m0_ack}); end
        @(negedge clk);
        n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL t1_hold_ack_high: got %b want 01", gnt); end
        s_ack_in = 0; s_rdat_in = 0;
        @(negedge clk);
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL t1_release: got %b want 00", gnt); end
    endtask

    task automatic test_round_robin();
        logic [1:0] seq [6];
        logic [1:0] prev, g;
        logic a0, a1, st;
        int ngr, gap;
        use_b = 0; rst_n = 0; clear_inputs();
        m0_stb = 1; m1_stb = 1; m0_adr = 32'hA0; m1_adr = 32'hB0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 6; i++) seq[i] = 2'b00;
        ngr = 0; gap = 0; prev = 2'b00;
        for (int c = 0; c < 200 && ngr < 6; c++) begin
            @(negedge clk);
            g = gnt; a0 = m0_ack; a1 = m1_ack; st = s_stb;
            if (g != 2'b00 && prev == 2'b00) begin
                seq[ngr] = g;
                if (ngr > 0) begin
                    n_cmp++; if (gap !== 1) begin n_bad++; $display("FAIL t2_idle_gap %0d: got %0d want 1", ngr, gap); end
                end
                ngr++;
            end
            gap = (g == 2'b00) ? gap + 1 : 0;
            prev = g;
            if (a0) m0_stb = 0; else if (!m0_stb) m0_stb = 1;
            if (a1) m1_stb = 0; else if (!m1_stb) m1_stb = 1;
            s_ack_in = st;
        end
        n_cmp++; if (ngr !== 6) begin n_bad++; $display("FAIL t2_grant_count: got %0d want 6", ngr); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (seq[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_bad++; $display("FAIL t2_order %0d: got %b want %b", i, seq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
    endtask

    task automatic test_ignore_other();
        use_b = 1; do_reset();
        m0_adr = 32'h200; m0_sel = 4'hF; m0_stb = 1;
        @(negedge clk);
        m1_adr = 32'h40; m1_we = 1; m1_wdat = 32'hCAFEF00D; m1_sel = 4'b0011; m1_stb = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 2) s_ack_in = 1;
            if (k == 3) m0_stb = 0;
            #1;
            n_cmp++;
            if ({gnt, s_we, m1_ack} !== 4'b0100) begin n_bad++; $display("FAIL t3_m0_phase %0d: got %b want 0100", k, {gnt, s_we, m1_ack}); end
        end
        @(negedge clk); s_ack_in = 0;
        @(negedge clk);
        n_cmp++; if ({gnt, s_we, m1_ack} !== 4'b0000) begin n_bad++; $display("FAIL t3_idle: got %b want 0000", {gnt, s_we, m1_ack}); end
        @(negedge clk);
        n_cmp++;
        if ({gnt, s_stb, s_we, s_adr, s_wdat, s_sel} !== {2'b10, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 4'b0011}) begin
            n_bad++; $display("FAIL t3_m1_write: got %h want %h", {gnt, s_stb, s_we, s_adr, s_wdat, s_sel}, {2'b10, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 4'b0011});
        end
        s_ack_in = 1; #1;
        n_cmp++; if ({m0_ack, m1_ack} !== 2'b01) begin n_bad++; $display("FAIL t3_m1_ack: got %b want 01", {m0_ack, m1_ack}); end
        @(negedge clk); m1_stb = 0;
        @(negedge clk); s_ack_in = 0;
        @(negedge clk);
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL t3_release: got %b want 00", gnt); end
    endtask

    task automatic test_timeout();
        use_b = 0; do_reset();
        m0_adr = 32'h300; m0_stb = 1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({gnt, s_stb, m0_ack, tmo} !== 5'b01100) begin n_bad++; $display("FAIL t4_wait %0d: got %b want 01100", k, {gnt, s_stb, m0_ack, tmo}); end
        end
        @(negedge clk);
        n_cmp++;
        if ({gnt, s_stb, m0_ack, m0_rdat, tmo} !== {2'b01, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1}) begin
            n_bad++; $display("FAIL t4_expire: got %h want %h", {gnt, s_stb, m0_ack, m0_rdat, tmo}, {2'b01, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1});
        end
        @(negedge clk);
        n_cmp++; if ({m0_ack, tmo, m1_ack} !== 3'b100) begin n_bad++; $display("FAIL t4_pulse_once: got %b want 100", {m0_ack, tmo, m1_ack}); end
        m0_stb = 0; s_ack_in = 1;
        @(negedge clk);
        n_cmp++; if ({gnt, m0_ack} !== 3'b000) begin n_bad++; $display("FAIL t4_release: got %b want 000", {gnt, m0_ack}); end
        s_ack_in = 0;
    endtask

    task automatic test_ack_at_limit();
        use_b = 0; do_reset();
        m0_stb = 1; s_rdat_in = 32'h5555AAAA;
        repeat (8) @(negedge clk);
        s_ack_in = 1;
        @(negedge clk);
        n_cmp++;
        if ({tmo, s_stb, m0_ack, m0_rdat} !== {1'b0, 1'b1, 1'b1, 32'h5555AAAA}) begin
            n_bad++; $display("FAIL t4_ack_wins: got %h want %h", {tmo, s_stb, m0_ack, m0_rdat}, {1'b0, 1'b1, 1'b1, 32'h5555AAAA});
        end
        m0_stb = 0;
        @(negedge clk); s_ack_in = 0;
        @(negedge clk);
        n_cmp++; if ({gnt, tmo} !== 3'b000) begin n_bad++; $display("FAIL t4_ack_release: got %b want 000", {gnt, tmo}); end
    endtask

    task automatic test_reset_midbusy();
        use_b = 0; do_reset();
        m0_stb = 1; @(negedge clk); @(negedge clk);
        s_ack_in = 1; @(negedge clk); m0_stb = 0; @(negedge clk); s_ack_in = 0; @(negedge clk);
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL t5_first_done: got %b want 00", gnt); end
        m0_stb = 1; m0_adr = 32'h700; @(negedge clk); @(negedge clk);
        s_ack_in = 1; s_rdat_in = 32'h77; #1;
        n_cmp++; if ({gnt, s_stb, m0_ack} !== 4'b0111) begin n_bad++; $display("FAIL t5_busy: got %b want 0111", {gnt, s_stb, m0_ack}); end
        @(posedge clk); #2; rst_n = 0; #1;
        n_cmp++;
        if ({s_stb, gnt, m0_ack, m1_ack, m0_rdat, s_adr} !== '0) begin
            n_bad++; $display("FAIL t5_async: got %h want 0", {s_stb, gnt, m0_ack, m1_ack, m0_rdat, s_adr});
        end
        m1_stb = 1; s_ack_in = 0;
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL t5_m0_first: got %b want 01", gnt); end
    endtask

    task automatic test_no_timeout();
        use_b = 1; do_reset();
        m0_adr = 32'h500; m0_stb = 1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({gnt, s_stb, m0_ack, tmo} !== 5'b01100) begin n_bad++; $display("FAIL t6_wait %0d: got %b want 01100", k, {gnt, s_stb, m0_ack, tmo}); end
        end
        s_ack_in = 1; s_rdat_in = 32'h0BADF00D; #1;
        n_cmp++;
        if ({m0_ack, m0_rdat, tmo} !== {1'b1, 32'h0BADF00D, 1'b0}) begin
            n_bad++; $display("FAIL t6_late_ack: got %h want %h", {m0_ack, m0_rdat, tmo}, {1'b1, 32'h0BADF00D, 1'b0});
        end
        @(negedge clk); m0_stb = 0;
        @(negedge clk); s_ack_in = 0; #1;
        n_cmp++; if ({m0_ack, tmo} !== 2'b00) begin n_bad++; $display("FAIL t6_ack_follow: got %b want 00", {m0_ack, tmo}); end
        @(negedge clk);
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL t6_release: got %b want 00", gnt); end
    endtask

    task automatic test_random();
        logic       mlast, p0, p1, pa, w, gi, a0, a1, st;
        logic [1:0] p_gnt, eg;
        logic [69:0] es;
        logic [66:0] em;
        int idle0, idle1, lat;
        use_b = 0; do_reset();
        mlast = 1; p_gnt = 0; p0 = 0; p1 = 0; pa = 0; idle0 = 0; idle1 = 0;
        lat = int'($urandom_range(0, 5));
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (p_gnt == 2'b00) begin
                w  = (p0 && p1) ? !mlast : p1;
                eg = (p0 || p1) ? (w ? 2'b10 : 2'b01) : 2'b00;
            end else begin
                gi = p_gnt[1];
                if ((gi ? p1 : p0) || pa) eg = p_gnt;
                else begin eg = 2'b00; mlast = gi; end
            end
            n_cmp++; if (gnt !== eg) begin n_bad++; $display("FAIL rnd_gnt cyc %0d: got %b want %b", c, gnt, eg); end
            es = eg[0] ? {m0_stb, m0_we, m0_adr, m0_wdat, m0_sel} :
                 eg[1] ? {m1_stb, m1_we, m1_adr, m1_wdat, m1_sel} : 70'h0;
            n_cmp++;
            if ({s_stb, s_we, s_adr, s_wdat, s_sel} !== es) begin
                n_bad++; $display("FAIL rnd_slave cyc %0d: got %h want %h", c, {s_stb, s_we, s_adr, s_wdat, s_sel}, es);
            end
            em = {eg[0] & s_ack_in, eg[0] ? s_rdat_in : 32'h0, eg[1] & s_ack_in, eg[1] ? s_rdat_in : 32'h0, 1'b0};
            n_cmp++;
            if ({m0_ack, m0_rdat, m1_ack, m1_rdat, tmo} !== em) begin
                n_bad++; $display("FAIL rnd_master cyc %0d: got %h want %h", c, {m0_ack, m0_rdat, m1_ack, m1_rdat, tmo}, em);
            end
            a0 = m0_ack; a1 = m1_ack; st = s_stb;
            if (a0) m0_stb = 0;
            else if (!m0_stb) begin
                if (idle0 > 0) idle0--;
                else if ($urandom_range(0, 2) != 0) begin m0_stb = 1; idle0 = int'($urandom_range(0, 3)); end
                m0_we = 1'($urandom_range(0, 1)); m0_adr = $urandom; m0_wdat = $urandom; m0_sel = 4'($urandom);
            end
            if (a1) m1_stb = 0;
            else if (!m1_stb) begin
                if (idle1 > 0) idle1--;
                else if ($urandom_range(0, 2) != 0) begin m1_stb = 1; idle1 = int'($urandom_range(0, 3)); end
                m1_we = 1'($urandom_range(0, 1)); m1_adr = $urandom; m1_wdat = $urandom; m1_sel = 4'($urandom);
            end
            if (st && !s_ack_in) begin
                if (lat == 0) begin s_ack_in = 1; s_rdat_in = $urandom; end
                else lat--;
            end else if (!st && s_ack_in) begin
                s_ack_in = 0; lat = int'($urandom_range(0, 5));
            end
            p_gnt = eg; p0 = m0_stb; p1 = m1_stb; pa = s_ack_in;
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; use_b = 0; rst_n = 0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_ignore_other();
        test_timeout();
        test_ack_at_limit();
        test_reset_midbusy();
        test_no_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        n_bad++;
        $display("FAIL sim_time_limit: got no end of tests, want end before limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "time limit");
    end
endmodule
